ped_request_ctrl: RTL and testbench

//  Pedestrian-side partner of the traffic_light controller. Debounces a crossing button, drives the

---
 rtl/ped_request_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ped_request_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ped_request_ctrl.sv
// Pedestrian crossing front-end: debounces the push-button, requests the crossing from the
// traffic controller and drives WALK / DONT_WALK. Define WALK_FLASH_EN to flash DONT_WALK in CLEAR.
module ped_request_ctrl #(
  parameter int DEB_CYCLES  = 16,
  parameter int SHORT_GREEN = 10,
  parameter int WALK_GUARD  = 3
`ifdef WALK_FLASH_EN
  ,
  parameter int FLASH_DIV   = 4
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  input  logic [7:0] clock,
  output logic       pass_request,
  output logic       walk,
  output logic       dont_walk,
  output logic       light_err,
  output logic [7:0] req_cnt
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [7:0] SHORT_GREEN_U = 8'(SHORT_GREEN);
  localparam logic [7:0] WALK_GUARD_U  = 8'(WALK_GUARD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT_RED,
    S_WALK,
    S_CLEAR
  } state_t;

  logic          sync1_reg, sync2_reg;
  logic          btn_db_reg;
  logic [DW-1:0] deb_cnt_reg;
  logic          press;

  state_t        state_reg, state_next;
  logic          pending_reg, pending_next;
  logic [7:0]    req_cnt_reg, req_cnt_next;
  logic          pass_request_reg, walk_reg, dont_walk_reg, light_err_reg;
  logic          multi_lamp;

  // press fires on the same edge that commits the rising debounced level
  assign press = sync2_reg & ~btn_db_reg & (deb_cnt_reg == DEB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      btn_db_reg  <= 1'b0;
      deb_cnt_reg <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg != btn_db_reg) begin
        if (deb_cnt_reg == DEB_LAST) begin
          btn_db_reg  <= sync2_reg;
          deb_cnt_reg <= '0;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + DW'(1);
        end
      end else begin
        deb_cnt_reg <= '0;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    req_cnt_next = req_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (press || pending_reg) begin
          state_next   = S_ARMED;
          pending_next = 1'b0;
          if (req_cnt_reg != 8'hFF) req_cnt_next = req_cnt_reg + 8'd1;
        end
      end
      S_ARMED: begin
        if (red)                                    state_next = S_WALK;
        else if (yellow)                            state_next = S_WAIT_RED;
        else if (green && (clock <= SHORT_GREEN_U)) state_next = S_WAIT_RED;
      end
      S_WAIT_RED: begin
        if (red) state_next = S_WALK;
      end
      S_WALK: begin
        if ((clock <= WALK_GUARD_U) || !red) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        if (press) pending_next = 1'b1;
        if (!red)  state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign multi_lamp = (red & yellow) | (red & green) | (yellow & green);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      pending_reg      <= 1'b0;
      req_cnt_reg      <= 8'd0;
      pass_request_reg <= 1'b0;
      walk_reg         <= 1'b0;
      light_err_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pending_reg      <= pending_next;
      req_cnt_reg      <= req_cnt_next;
      pass_request_reg <= (state_next == S_ARMED);
      walk_reg         <= (state_next == S_WALK);
      light_err_reg    <= light_err_reg | multi_lamp;
    end
  end

`ifdef WALK_FLASH_EN
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);
  logic [FW-1:0] flash_cnt_reg;

  // entering CLEAR lands in the final branch, so the flash always starts lit
  always_ff @(posedge clk) begin
    if (rst) begin
      flash_cnt_reg <= '0;
      dont_walk_reg <= 1'b1;
    end else if (state_next == S_WALK) begin
      flash_cnt_reg <= '0;
      dont_walk_reg <= 1'b0;
    end else if ((state_next == S_CLEAR) && (state_reg == S_CLEAR)) begin
      if (flash_cnt_reg == FLASH_LAST) begin
        flash_cnt_reg <= '0;
        dont_walk_reg <= ~dont_walk_reg;
      end else begin
        flash_cnt_reg <= flash_cnt_reg + FW'(1);
      end
    end else begin
      flash_cnt_reg <= '0;
      dont_walk_reg <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) dont_walk_reg <= 1'b1;
    else     dont_walk_reg <= (state_next != S_WALK);
  end
`endif

  assign pass_request = pass_request_reg;
  assign walk         = walk_reg;
  assign dont_walk    = dont_walk_reg;
  assign light_err    = light_err_reg;
  assign req_cnt      = req_cnt_reg;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Bench for ped_request_ctrl: directed scenarios plus random lamp/button traffic, all checked
// against a phase-level reference model built from the crossing rules.
module tb_ped_request_ctrl;
  localparam int DEB = 16;
  localparam int SG  = 10;
  localparam int WG  = 3;
  localparam int FD  = 4;

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_WAIT  = 2;
  localparam int P_WALK  = 3;
  localparam int P_CLEAR = 4;

  logic       clk = 1'b0;
  logic       rst, btn_raw, red, yellow, green;
  logic [7:0] clock;
  logic       pass_request, walk, dont_walk, light_err;
  logic [7:0] req_cnt;

  int checks = 0;
  int errors = 0;

  int  m_phase = P_IDLE;
  int  m_req = 0;
  int  m_k = 0;
  bit  m_pend = 0, m_err = 0, m_db = 0, m_s1 = 0, m_s2 = 0;
  bit  samp[$];

  always #5 clk = ~clk;

  ped_request_ctrl #(
    .DEB_CYCLES (DEB),
    .SHORT_GREEN(SG),
    .WALK_GUARD (WG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .clock       (clock),
    .pass_request(pass_request),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .light_err   (light_err),
    .req_cnt     (req_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_dont_walk();
    if (m_phase == P_WALK) return 1'b0;
`ifdef WALK_FLASH_EN
    if (m_phase == P_CLEAR) return ((m_k / FD) % 2) == 0;
`endif
    return 1'b1;
  endfunction

  // Reference: level changes once the last DEB debounce samples all disagree with it
  task automatic model_edge();
    bit seen, rise, all_diff;
    if (rst) begin
      m_phase = P_IDLE; m_req = 0; m_k = 0;
      m_pend = 0; m_err = 0; m_db = 0; m_s1 = 0; m_s2 = 0;
      samp.delete();
      return;
    end
    rise = 0;
    seen = m_s2; m_s2 = m_s1; m_s1 = btn_raw;
    samp.push_back(seen);
    if (samp.size() > DEB) void'(samp.pop_front());
    all_diff = 1;
    foreach (samp[i]) if (samp[i] == m_db) all_diff = 0;
    if (samp.size() == DEB && all_diff) begin
      rise = !m_db;
      m_db = !m_db;
    end
    if (int'(red) + int'(yellow) + int'(green) > 1) m_err = 1;
    case (m_phase)
      P_IDLE: if (rise || m_pend) begin
        m_phase = P_ARMED; m_pend = 0;
        m_req = (m_req < 255) ? m_req + 1 : 255;
      end
      P_ARMED: begin
        if (red) m_phase = P_WALK;
        else if (yellow || (green && int'(clock) <= SG)) m_phase = P_WAIT;
      end
      P_WAIT: if (red) m_phase = P_WALK;
      P_WALK: if (int'(clock) <= WG || !red) begin m_phase = P_CLEAR; m_k = 0; end
      default: begin
        if (rise) m_pend = 1;
        if (!red) m_phase = P_IDLE;
        else m_k++;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("pass_request", pass_request, (m_phase == P_ARMED));
    check("walk", walk, (m_phase == P_WALK));
    check("dont_walk", dont_walk, exp_dont_walk());
    check("light_err", light_err, m_err);
    check("req_cnt", req_cnt, m_req);
  endtask

  initial begin
    logic [15:0] pat, pat_exp;
    int r;
    rst = 1; btn_raw = 0; red = 0; yellow = 0; green = 0; clock = 8'd0;
    // 1: reset
    tick(); tick();
    check("rst_pass", pass_request, 0);
    check("rst_walk", walk, 0);
    check("rst_dw", dont_walk, 1);
    check("rst_req", req_cnt, 0);
    check("rst_err", light_err, 0);
    rst = 0;

    // 2: bouncing button, then a clean edge
    for (int c = 0; c < 40; c++) begin
      btn_raw = ((c / 3) % 2 == 0);
      tick();
    end
    btn_raw = 1;
    for (int i = 1; i <= 18; i++) begin
      tick();
      check("press_latency", pass_request, (i == 18));
    end
    check("req_after_bounce", req_cnt, 1);

    // 3: shortened green, then walk and guard
    green = 1; clock = 8'd45;
    repeat (3) tick();
    check("armed_long_green", pass_request, 1);
    clock = 8'd10; tick();
    check("short_green", pass_request, 0);
    green = 0; red = 1; clock = 8'd10; tick();
    check("walk_on_red", walk, 1);
    clock = 8'd3; tick();
    check("guard_walk", walk, 0);
    check("guard_dw", dont_walk, 1);
    btn_raw = 0;
    repeat (20) tick();
    red = 0; tick();

    // 4: press on red, pending press in CLEAR
    rst = 1; tick(); tick(); rst = 0;
    red = 1; clock = 8'd30; btn_raw = 1;
    repeat (18) tick();
    check("armed_on_red", pass_request, 1);
    check("req_first", req_cnt, 1);
    tick();
    check("walk_next", walk, 1);
    clock = 8'd3; btn_raw = 0; tick();
    pat[15] = dont_walk;
    for (int i = 1; i < 16; i++) begin
      tick();
      pat[15 - i] = dont_walk;
    end
`ifdef WALK_FLASH_EN
    pat_exp = 16'hF0F0;
`else
    pat_exp = 16'hFFFF;
`endif
    check("clear_dw_pattern", pat, pat_exp);
    repeat (4) tick();
    btn_raw = 1;
    repeat (18) tick();
    check("pending_not_counted", req_cnt, 1);
    red = 0; tick();
    check("idle_after_clear", pass_request, 0);
    tick();
    check("rearm_pending", pass_request, 1);
    check("req_second", req_cnt, 2);

    // 5: illegal lamps, sticky error
    red = 1; green = 1; tick();
    check("err_set", light_err, 1);
    green = 0; repeat (3) tick();
    check("err_sticky", light_err, 1);
    rst = 1; tick();
    check("err_cleared", light_err, 0);
    rst = 0; red = 0; btn_raw = 0;
    repeat (20) tick();

    // request counter saturation
    for (int n = 0; n < 258; n++) begin
      btn_raw = 1; red = 1; clock = 8'd30;
      repeat (19) tick();
      btn_raw = 0; red = 0;
      repeat (18) tick();
    end
    check("req_saturate", req_cnt, 255);

    // random traffic
    rst = 1; tick(); rst = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) btn_raw = ~btn_raw;
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 9);
        red = (r <= 2); yellow = (r == 3 || r == 4); green = (r >= 5 && r <= 7);
        if (r == 9) begin
          red = $urandom_range(0, 1) == 1;
          yellow = $urandom_range(0, 1) == 1;
          green = $urandom_range(0, 1) == 1;
        end
      end
      clock = 8'($urandom_range(0, 40));
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
